// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap/PC sequencer: owns the PC, mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause.
// Define RV_TRAP_COUNT_EN to add a trap-entry counter readable/writable at CSR 0xB03.
module rv_trap_ctrl #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               ecall_i,
    input  logic               ill_instr_i,
    input  logic               mret_i,
    input  logic [31:0]        pc_next_i,
    input  logic               csr_we_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [31:0]        csr_wdata_i,
    output logic [31:0]        csr_rdata_o,
    output logic [31:0]        pc_o,
    output logic               trap_taken_o
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMip     = 12'h344;
    localparam logic [11:0] CsrTrapCnt = 12'hB03;

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic               status_mie_q, status_mie_d;
    logic               status_mpie_q, status_mpie_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic               trap_taken_q;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [3:0]         irq_idx;
    logic               irq_hit;
    logic [4:0]         irq_code;
    logic [31:0]        mtvec_base;
    logic [31:0]        irq_target;
    logic               trap;
    logic [31:0]        cnt_rdata;

    // Lowest-index eligible interrupt wins.
    always_comb begin
        eligible   = pending_q & mie_q & {NUM_IRQ{status_mie_q}};
        irq_hit    = 1'b0;
        irq_idx    = 4'd0;
        irq_onehot = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (eligible[i] && !irq_hit) begin
                irq_hit       = 1'b1;
                irq_idx       = 4'(i);
                irq_onehot[i] = 1'b1;
            end
        end
        irq_code   = 5'd16 + {1'b0, irq_idx};
        mtvec_base = {mtvec_q[31:2], 2'b00};
        irq_target = mtvec_q[0] ? (mtvec_base + {25'd0, irq_code, 2'b00}) : mtvec_base;
    end

    always_comb begin
        pc_d          = pc_next_i;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mie_d         = mie_q;
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        trap          = 1'b0;

        if (csr_we_i) begin
            case (csr_addr_i)
                CsrMstatus: begin
                    status_mie_d  = csr_wdata_i[3];
                    status_mpie_d = csr_wdata_i[7];
                end
                CsrMie:    mie_d    = csr_wdata_i[NUM_IRQ-1:0];
                CsrMtvec:  mtvec_d  = {csr_wdata_i[31:2], 1'b0, csr_wdata_i[0]};
                CsrMepc:   mepc_d   = {csr_wdata_i[31:2], 2'b00};
                CsrMcause: mcause_d = csr_wdata_i;
                default: ;
            endcase
        end

        // Trap/mret updates are applied last so they override a colliding CSR write.
        if (irq_hit) begin
            trap          = 1'b1;
            mepc_d        = pc_next_i;
            mcause_d      = {1'b1, 26'd0, irq_code};
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            pc_d          = irq_target;
        end else if (ill_instr_i) begin
            trap          = 1'b1;
            mepc_d        = pc_q;
            mcause_d      = 32'd2;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            pc_d          = mtvec_base;
        end else if (ecall_i) begin
            trap          = 1'b1;
            mepc_d        = pc_q;
            mcause_d      = 32'd11;
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            pc_d          = mtvec_base;
        end else if (mret_i) begin
            pc_d          = mepc_q;
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
        end

        // A new rising edge beats the clear of the interrupt just taken.
        pending_d = (pending_q & ~irq_onehot) | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= RESET_PC;
            mtvec_q       <= MTVEC_RESET;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mie_q         <= '0;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            pending_q     <= '0;
            irq_q         <= '0;
            trap_taken_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mie_q         <= mie_d;
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            pending_q     <= pending_d;
            irq_q         <= irq_i;
            trap_taken_q  <= trap;
        end
    end

`ifdef RV_TRAP_COUNT_EN
    logic [31:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        trap_cnt_d = trap_cnt_q;
        if (trap) begin
            trap_cnt_d = trap_cnt_q + 32'd1;
        end
        if (csr_we_i && (csr_addr_i == CsrTrapCnt)) begin
            trap_cnt_d = csr_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            trap_cnt_q <= 32'd0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign cnt_rdata = trap_cnt_q;
`else
    assign cnt_rdata = 32'd0;
`endif

    always_comb begin
        csr_rdata_o = 32'd0;
        case (csr_addr_i)
            CsrMstatus: csr_rdata_o = {24'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
            CsrMie:     csr_rdata_o = 32'(mie_q);
            CsrMtvec:   csr_rdata_o = mtvec_q;
            CsrMepc:    csr_rdata_o = mepc_q;
            CsrMcause:  csr_rdata_o = mcause_q;
            CsrMip:     csr_rdata_o = 32'(pending_q);
            CsrTrapCnt: csr_rdata_o = cnt_rdata;
            default:    csr_rdata_o = 32'd0;
        endcase
    end

    assign pc_o         = pc_q;
    assign trap_taken_o = trap_taken_q;

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Directed self-checking bench for rv_trap_ctrl (RESET_PC = 0x100, NUM_IRQ = 4).
module tb_rv_trap_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  irq;
    logic        ecall;
    logic        ill_instr;
    logic        mret;
    logic [31:0] pc_next;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] pc;
    logic        trap_taken;

    int checks = 0;
    int errors = 0;

    rv_trap_ctrl #(
        .NUM_IRQ    (4),
        .RESET_PC   (32'h0000_0100),
        .MTVEC_RESET(32'h0000_0000)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .irq_i       (irq),
        .ecall_i     (ecall),
        .ill_instr_i (ill_instr),
        .mret_i      (mret),
        .pc_next_i   (pc_next),
        .csr_we_i    (csr_we),
        .csr_addr_i  (csr_addr),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .pc_o        (pc),
        .trap_taken_o(trap_taken)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        chk(tag, csr_rdata, exp);
        csr_addr = 12'h000;
    endtask

    task automatic wr_csr(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 32'd0;
    endtask

    initial begin
        reset = 1'b1; irq = 4'b0; ecall = 1'b0; ill_instr = 1'b0; mret = 1'b0;
        pc_next = 32'h0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("reset_pc", pc, 32'h100);
        chk("reset_trap_taken", {31'd0, trap_taken}, 32'd0);
        chk_csr("reset_mstatus", 12'h300, 32'h0);
        chk_csr("reset_mtvec", 12'h305, 32'h0);
        chk_csr("reset_mepc", 12'h341, 32'h0);
        chk_csr("reset_mcause", 12'h342, 32'h0);
        chk_csr("reset_mip", 12'h344, 32'h0);
        chk_csr("unmapped", 12'h123, 32'h0);
        chk_csr("reset_cnt", 12'hB03, 32'h0);
        pc_next = 32'h104; step(); chk("seq_pc1", pc, 32'h104);
        pc_next = 32'h108; step(); chk("seq_pc2", pc, 32'h108);

        // Vectored setup; mtvec bit1 and mie upper bits are dropped
        pc_next = 32'h10C; wr_csr(12'h305, 32'h203);
        pc_next = 32'h110; wr_csr(12'h304, 32'hFF);
        pc_next = 32'h03C; wr_csr(12'h300, 32'h8);
        chk_csr("mtvec_wr", 12'h305, 32'h201);
        chk_csr("mie_wr", 12'h304, 32'hF);
        chk_csr("mstatus_wr", 12'h300, 32'h8);
        chk("pc_3c", pc, 32'h3C);

        // irq[2] and irq[1] together: edge latches, then irq1 wins
        irq = 4'b0110; pc_next = 32'h40; step();
        chk("pc_40", pc, 32'h40);
        chk_csr("mip_latched", 12'h344, 32'h6);
        pc_next = 32'h44; step();
        chk("irq1_pc", pc, 32'h200 + 4 * 17);
        chk("irq1_tt", {31'd0, trap_taken}, 32'd1);
        chk_csr("irq1_mepc", 12'h341, 32'h44);
        chk_csr("irq1_mcause", 12'h342, 32'h8000_0011);
        chk_csr("irq1_mstatus", 12'h300, 32'h80);
        chk_csr("irq1_mip", 12'h344, 32'h4);
        mret = 1'b1; pc_next = 32'h248; step(); mret = 1'b0;
        chk("mret1_pc", pc, 32'h44);
        chk("mret1_tt", {31'd0, trap_taken}, 32'd0);
        chk_csr("mret1_mstatus", 12'h300, 32'h88);
        pc_next = 32'h48; step();
        chk("irq2_pc", pc, 32'h200 + 4 * 18);
        chk_csr("irq2_mcause", 12'h342, 32'h8000_0012);
        chk_csr("irq2_mepc", 12'h341, 32'h48);
        chk_csr("irq2_mip", 12'h344, 32'h0);
        mret = 1'b1; step(); mret = 1'b0;
        chk("mret2_pc", pc, 32'h48);
        pc_next = 32'h4C; step();
        chk("no_retrig_pc", pc, 32'h4C);
        chk("no_retrig_tt", {31'd0, trap_taken}, 32'd0);
        irq = 4'b0;

        // irq[0] held high with MIE = 0: no trap until MIE set, then exactly one
        pc_next = 32'h50; wr_csr(12'h300, 32'h0);
        irq = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            pc_next = 32'h54 + 32'(4 * k);
            step();
            chk("masked_pc", pc, 32'h54 + 32'(4 * k));
            chk("masked_tt", {31'd0, trap_taken}, 32'd0);
        end
        chk_csr("masked_mip", 12'h344, 32'h1);
        pc_next = 32'h68; wr_csr(12'h300, 32'h8);
        chk("mie_set_pc", pc, 32'h68);
        pc_next = 32'h6C; step();
        chk("irq0_pc", pc, 32'h240);
        chk_csr("irq0_mcause", 12'h342, 32'h8000_0010);
        chk_csr("irq0_mepc", 12'h341, 32'h6C);
        mret = 1'b1; step(); mret = 1'b0;
        chk("mret3_pc", pc, 32'h6C);
        for (int k = 0; k < 3; k++) begin
            pc_next = 32'h70 + 32'(4 * k);
            step();
            chk("held_pc", pc, 32'h70 + 32'(4 * k));
            chk("held_tt", {31'd0, trap_taken}, 32'd0);
        end
        irq = 4'b0;

        // ill_instr beats ecall; direct mtvec
        pc_next = 32'h80; wr_csr(12'h305, 32'h300);
        ill_instr = 1'b1; ecall = 1'b1; pc_next = 32'h84; step();
        ill_instr = 1'b0; ecall = 1'b0;
        chk("ill_pc", pc, 32'h300);
        chk("ill_tt", {31'd0, trap_taken}, 32'd1);
        chk_csr("ill_mepc", 12'h341, 32'h80);
        chk_csr("ill_mcause", 12'h342, 32'h2);
        chk_csr("ill_mstatus", 12'h300, 32'h80);
        mret = 1'b1; pc_next = 32'h304; step(); mret = 1'b0;
        chk("mret4_pc", pc, 32'h80);

        // ecall wins over a simultaneous mepc write
        pc_next = 32'h90; step();
        ecall = 1'b1; pc_next = 32'h94; wr_csr(12'h341, 32'h1234); ecall = 1'b0;
        chk("ecall_pc", pc, 32'h300);
        chk_csr("ecall_mepc", 12'h341, 32'h90);
        chk_csr("ecall_mcause", 12'h342, 32'hB);

        // Write masks and read-only mip
        pc_next = 32'h304; wr_csr(12'h341, 32'h1237);
        chk_csr("mepc_mask", 12'h341, 32'h1234);
        wr_csr(12'h342, 32'h5);
        chk_csr("mcause_wr", 12'h342, 32'h5);
        wr_csr(12'h344, 32'hF);
        chk_csr("mip_ro", 12'h344, 32'h0);

        // Direct mode sends interrupts to base too
        wr_csr(12'h300, 32'h8);
        irq = 4'b1000; pc_next = 32'h308; step();
        pc_next = 32'h30C; step();
        irq = 4'b0;
        chk("irq3_direct_pc", pc, 32'h300);
        chk_csr("irq3_mcause", 12'h342, 32'h8000_0013);
        chk_csr("irq3_mepc", 12'h341, 32'h30C);

`ifdef RV_TRAP_COUNT_EN
        pc_next = 32'h310; wr_csr(12'hB03, 32'hFFFF_FFFF);
        chk_csr("cnt_preload", 12'hB03, 32'hFFFF_FFFF);
        ecall = 1'b1; step(); ecall = 1'b0;
        chk_csr("cnt_wrap", 12'hB03, 32'h0);
        ecall = 1'b1; wr_csr(12'hB03, 32'h5); ecall = 1'b0;
        chk_csr("cnt_wr_wins", 12'hB03, 32'h5);
`else
        pc_next = 32'h310; wr_csr(12'hB03, 32'h1234);
        chk_csr("cnt_absent", 12'hB03, 32'h0);
`endif

        // Reset mid-handler discards trap state
        ecall = 1'b1; step(); ecall = 1'b0;
        chk("pre_reset_tt", {31'd0, trap_taken}, 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_pc", pc, 32'h100);
        chk("rst2_tt", {31'd0, trap_taken}, 32'd0);
        chk_csr("rst2_mepc", 12'h341, 32'h0);
        chk_csr("rst2_mcause", 12'h342, 32'h0);
        chk_csr("rst2_mstatus", 12'h300, 32'h0);
        chk_csr("rst2_mtvec", 12'h305, 32'h0);
        chk_csr("rst2_mie", 12'h304, 32'h0);
        chk_csr("rst2_cnt", 12'hB03, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
